// File: rtl/core_scheduler.sv
// core_scheduler: per-core instruction sequencing FSM for the MiniGPU compute core.
// Optional feature: define SCHED_DIVERGE_CHECK_EN to add the sticky next_pc divergence check (diverge_err).
module core_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
  input  logic                                 fetch_valid,
  input  logic                                 decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                           core_state,
  output logic                                 fetch_req,
  output logic [PC_BITS-1:0]                   current_pc,
  output logic                                 done,
  output logic [15:0]                          retired
`ifdef SCHED_DIVERGE_CHECK_EN
  ,
  output logic                                 diverge_err
`endif
);

  localparam int CNT_W = $clog2(THREADS_PER_BLOCK) + 1;

  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;

  // Encoding is visible to the decoder, ALUs and LSUs, so it must stay fixed.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   active_lanes;
  logic [PC_BITS-1:0] lane0_pc;
  logic               lsu_busy;
  logic               pc_mismatch;
  logic               diverge;

  // A zero lane count still runs lane 0.
  assign active_lanes = (thread_count == '0) ? CNT_W'(1) : thread_count;
  assign lane0_pc     = next_pc[PC_BITS-1:0];
  assign core_state   = state;

  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if ((i < int'(active_lanes)) &&
          ((lsu_state[2*i +: 2] == LSU_REQUESTING) || (lsu_state[2*i +: 2] == LSU_WAITING)))
        lsu_busy = 1'b1;
    end
  end

`ifdef SCHED_DIVERGE_CHECK_EN
  always_comb begin
    pc_mismatch = 1'b0;
    for (int i = 1; i < THREADS_PER_BLOCK; i++) begin
      if ((i < int'(active_lanes)) && (next_pc[i*PC_BITS +: PC_BITS] != lane0_pc))
        pc_mismatch = 1'b1;
    end
  end
`else
  logic unused_next_pc;

  assign pc_mismatch    = 1'b0;
  assign unused_next_pc = ^next_pc;
`endif

  // A RET takes precedence: the kernel ended normally, so no divergence is flagged.
  assign diverge = pc_mismatch && !decoded_ret;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    fetch_req  = 1'b0;
    case (state)
      S_IDLE:    if (start) state_next = S_FETCH;
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_valid) state_next = S_DECODE;
      end
      S_DECODE:  state_next = S_REQUEST;
      S_REQUEST: state_next = S_WAIT;
      S_WAIT:    if (!lsu_busy) state_next = S_EXECUTE;
      S_EXECUTE: state_next = S_UPDATE;
      S_UPDATE:  state_next = (decoded_ret || diverge) ? S_DONE : S_FETCH;
      S_DONE:    if (!start) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_pc <= '0;
      done       <= 1'b0;
      retired    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            current_pc <= '0;
            retired    <= '0;
          end
        end
        S_UPDATE: begin
          if (retired != 16'hFFFF) retired <= retired + 16'd1;
          if (decoded_ret || diverge) done       <= 1'b1;
          else                        current_pc <= lane0_pc;
        end
        S_DONE: begin
          if (!start) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SCHED_DIVERGE_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               diverge_err <= 1'b0;
    else if ((state == S_UPDATE) && diverge)  diverge_err <= 1'b1;
    else if ((state == S_DONE) && !start)     diverge_err <= 1'b0;
  end
`endif

  // done is a registered copy of "in DONE"; both change on the same edges.
  a_done_tracks_state: assert property (@(posedge clk) disable iff (!reset)
    done == (state == S_DONE));

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: vector table, hand-written corner sequences and
// randomized instructions scored against a cycle-count/PC reference model.
module tb_core_scheduler;

  localparam int T   = 4;
  localparam int PCB = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_REQUEST = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_EXECUTE = 3'd5;
  localparam logic [2:0] ST_UPDATE  = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  logic           clk          = 1'b0;
  logic           reset        = 1'b1;
  logic           start        = 1'b0;
  logic [2:0]     thread_count = 3'd4;
  logic           fetch_valid  = 1'b0;
  logic           decoded_ret  = 1'b0;
  logic [2*T-1:0] lsu_state    = '0;
  logic [PCB*T-1:0] next_pc    = '0;
  logic [2:0]     core_state;
  logic           fetch_req;
  logic [PCB-1:0] current_pc;
  logic           done;
  logic [15:0]    retired;
`ifdef SCHED_DIVERGE_CHECK_EN
  logic           diverge_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int m_pc  = 0;
  int m_ret = 0;
  bit m_div = 1'b0;

  core_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(PCB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .thread_count (thread_count),
    .fetch_valid  (fetch_valid),
    .decoded_ret  (decoded_ret),
    .lsu_state    (lsu_state),
    .next_pc      (next_pc),
    .core_state   (core_state),
    .fetch_req    (fetch_req),
    .current_pc   (current_pc),
    .done         (done),
    .retired      (retired)
`ifdef SCHED_DIVERGE_CHECK_EN
    ,
    .diverge_err  (diverge_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tc;
    int         lane;
    logic [1:0] val;
    int         n;
    int         exp_wait;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     core_state, ST_IDLE);
    check({tag, "_pc"},        current_pc, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_retired"},   retired, 0);
    check({tag, "_fetch_req"}, fetch_req, 0);
`ifdef SCHED_DIVERGE_CHECK_EN
    check({tag, "_div_err"},   diverge_err, 0);
`endif
  endtask

  task automatic launch();
    check("launch_from_idle", core_state, ST_IDLE);
    start = 1'b1;
    step();
    m_pc  = 0;
    m_ret = 0;
    check("launch_state", core_state, ST_FETCH);
    check("launch_pc", current_pc, 0);
    check("launch_retired", retired, 0);
    check("launch_fetch_req", fetch_req, 1);
  endtask

  task automatic finish_kernel();
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("done_hold_state", core_state, ST_DONE);
      check("done_hold_flag", done, 1);
      step();
    end
    start = 1'b0;
    step();
    m_div = 1'b0;
    check("done_exit_state", core_state, ST_IDLE);
    check("done_exit_flag", done, 0);
`ifdef SCHED_DIVERGE_CHECK_EN
    check("done_exit_div_err", diverge_err, 0);
`endif
  endtask

  // Drive one instruction starting in FETCH and score it against the reference model.
  task automatic instr(input string tag, input int fd, input int tc, input int lane,
                       input logic [1:0] val, input int n, input logic ret,
                       input logic [PCB*T-1:0] npc, input bit rand_start,
                       output int wait_cyc, output int total, output bit exp_end);
    int         fetch_cyc, req_cyc, busy_left, guard, act, exp_wait;
    logic [2:0] st;
    bit         busy, div;
    fetch_cyc = 0; req_cyc = 0; wait_cyc = 0; total = 0; busy_left = 0; guard = 0;
    thread_count = 3'(tc);
    decoded_ret  = ret;
    next_pc      = npc;
    do begin
      st = core_state;
      if (st == ST_FETCH) begin
        fetch_valid = (fetch_cyc >= fd);
        fetch_cyc++;
      end else begin
        fetch_valid = 1'b0;
      end
      if (fetch_req) req_cyc++;
      if (st == ST_REQUEST) busy_left = n;
      lsu_state = '0;
      if (busy_left > 0) begin
        lsu_state[2*lane +: 2] = val;
        busy_left--;
      end
      if (st == ST_WAIT) wait_cyc++;
      if (rand_start) start = 1'($urandom_range(0, 1));
      total++;
      guard++;
      step();
    end while (st != ST_UPDATE && guard < 400);
    lsu_state   = '0;
    fetch_valid = 1'b0;
    start       = 1'b1;
    check({tag, "_reached_update"}, st, ST_UPDATE);

    act      = (tc == 0) ? 1 : tc;
    busy     = (lane < act) && (val == 2'b01 || val == 2'b10) && (n > 0);
    exp_wait = busy ? n : 1;
    div      = 1'b0;
`ifdef SCHED_DIVERGE_CHECK_EN
    for (int i = 1; i < act && i < T; i++)
      if (npc[i*PCB +: PCB] != npc[PCB-1:0]) div = 1'b1;
    if (ret) div = 1'b0;
`endif
    m_ret   = (m_ret >= 65535) ? 65535 : m_ret + 1;
    if (!ret && !div) m_pc = int'(npc[PCB-1:0]);
    m_div   = m_div | div;
    exp_end = ret || div;

    check({tag, "_fetch_cycles"}, fetch_cyc, fd + 1);
    check({tag, "_fetch_req_cycles"}, req_cyc, fd + 1);
    check({tag, "_wait_cycles"}, wait_cyc, exp_wait);
    check({tag, "_instr_cycles"}, total, fd + 5 + exp_wait);
    check({tag, "_pc"}, current_pc, m_pc);
    check({tag, "_retired"}, retired, m_ret);
    check({tag, "_next_state"}, core_state, exp_end ? ST_DONE : ST_FETCH);
    check({tag, "_done"}, done, exp_end);
`ifdef SCHED_DIVERGE_CHECK_EN
    check({tag, "_div_err"}, diverge_err, m_div);
`endif
  endtask

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int             w, t, sum, g;
    bit             e;
    logic [2:0]     seq [6];
    logic [PCB*T-1:0] div_npc, npc;
    logic [PCB-1:0] l0;

    vecs[0] = '{4, 2, 2'b10, 5, 5};
    vecs[1] = '{2, 2, 2'b10, 5, 1};
    vecs[2] = '{0, 0, 2'b01, 3, 3};
    vecs[3] = '{0, 1, 2'b01, 3, 1};
    vecs[4] = '{1, 1, 2'b10, 4, 1};
    vecs[5] = '{3, 2, 2'b01, 2, 2};
    vecs[6] = '{4, 3, 2'b10, 1, 1};
    vecs[7] = '{4, 3, 2'b10, 2, 2};
    vecs[8] = '{4, 0, 2'b00, 0, 1};
    vecs[9] = '{4, 1, 2'b11, 4, 1};

    // Asynchronous reset before the first clock edge.
    #2 reset = 1'b0;
    #1 check_reset_values("por");
    step();
    #3 reset = 1'b1;
    step();
    step();
    check("idle_no_start", core_state, ST_IDLE);

    // Straight-line kernel: hand-checked first instruction, RET at PC 3.
    launch();
    fetch_valid = 1'b1;
    next_pc     = {T{8'd1}};
    seq = '{ST_FETCH, ST_DECODE, ST_REQUEST, ST_WAIT, ST_EXECUTE, ST_UPDATE};
    for (int k = 0; k < 6; k++) begin
      check("seq_state", core_state, seq[k]);
      step();
    end
    m_pc = 1;
    m_ret = 1;
    check("seq_pc", current_pc, 1);
    sum = 6;
    for (int k = 1; k < 4; k++) begin
      instr("line", 0, 4, 0, 2'b00, 0, (k == 3), {T{PCB'(k + 1)}}, 1'b0, w, t, e);
      sum += t;
    end
    check("line_cycles", sum, 24);
    check("line_done", done, 1);
    check("line_retired", retired, 4);
    check("line_pc", current_pc, 3);
    finish_kernel();

    // Table: WAIT length versus busy lane, LSU code and thread_count.
    launch();
    for (int i = 0; i < 10; i++) begin
      instr("vec", 0, vecs[i].tc, vecs[i].lane, vecs[i].val, vecs[i].n, 1'b0,
            {T{PCB'(m_pc + 1)}}, 1'b0, w, t, e);
      check("vec_wait", w, vecs[i].exp_wait);
      check("vec_total", t, 5 + vecs[i].exp_wait);
    end

    // Fetch stall of 7 cycles, then a branch and a RET.
    instr("fstall", 7, 4, 0, 2'b00, 0, 1'b0, {T{PCB'(m_pc + 1)}}, 1'b0, w, t, e);
    instr("branch", 0, 4, 0, 2'b00, 0, 1'b0, {T{8'h20}}, 1'b0, w, t, e);
    check("branch_pc", current_pc, 8'h20);
    instr("ret", 0, 4, 0, 2'b00, 0, 1'b1, {T{8'h77}}, 1'b0, w, t, e);
    check("ret_pc_hold", current_pc, 8'h20);
    finish_kernel();

    // Reset asserted mid-WAIT abandons the instruction.
    launch();
    instr("pre_rst", 0, 4, 0, 2'b00, 0, 1'b0, {T{8'h11}}, 1'b0, w, t, e);
    thread_count = 3'd4;
    fetch_valid  = 1'b1;
    lsu_state    = 8'b0000_0001;
    g = 0;
    while (core_state != ST_WAIT && g < 20) begin
      step();
      g++;
    end
    check("rst_reached_wait", core_state, ST_WAIT);
    step();
    #2 reset = 1'b0;
    #1 check_reset_values("rst_wait");
    step();
    step();
    check("rst_held_state", core_state, ST_IDLE);
    lsu_state   = '0;
    fetch_valid = 1'b0;
    start       = 1'b0;
    #2 reset = 1'b1;
    step();
    check_reset_values("rst_release");

    // Divergent next_pc: lanes 0/1 = 5/9, lanes 2/3 inactive.
    div_npc = {8'd7, 8'd7, 8'd9, 8'd5};
    launch();
    instr("div_tc2", 0, 2, 0, 2'b00, 0, 1'b0, div_npc, 1'b0, w, t, e);
`ifdef SCHED_DIVERGE_CHECK_EN
    check("div_err_set", diverge_err, 1);
    check("div_done", done, 1);
    check("div_pc_hold", current_pc, 0);
    finish_kernel();
    launch();
`else
    check("nodiv_lane0_pc", current_pc, 5);
`endif
    instr("div_tc1", 0, 1, 0, 2'b00, 0, 1'b0, div_npc, 1'b0, w, t, e);
    check("tc1_pc", current_pc, 5);
    instr("div_ret", 0, 1, 0, 2'b00, 0, 1'b1, div_npc, 1'b0, w, t, e);
    finish_kernel();

    // Randomized kernels; start toggles freely while an instruction is in flight.
    for (int kk = 0; kk < 3; kk++) begin
      launch();
      for (int j = 0; j < 25; j++) begin
        l0 = PCB'($urandom_range(0, 255));
        for (int i = 0; i < T; i++)
          npc[i*PCB +: PCB] = ($urandom_range(0, 1) == 1 || i == 0) ? l0 : PCB'($urandom_range(0, 255));
        instr("rnd", $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom_range(0, 6),
              (j == 24) || ($urandom_range(0, 7) == 0), npc, 1'b1, w, t, e);
        if (e || core_state == ST_DONE) break;
      end
      finish_kernel();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
